axis_write_data_strb: RTL and testbench

Next-generation AXI write-data channel engine. Accepts a narrow DATA_WIDTH stream and packs WIDTH_RATIO words per beat into AXI_DATA_WIDTH beats. Splits the transfer into bursts of up to 2^AXI_LEN_WIDTH beats and asserts wlast at each burst end. Adds byte strobes for lengths that are not a multiple of WIDTH_RATIO, an internal beat buffer and a done pulse. Sits beside the AXI write-address engine, which issues bursts using the same split rule.

---
 rtl/axis_write_data_strb_pkg.sv | 36 +++
 rtl/axis_write_data_strb_if.sv | 29 ++
 rtl/axis_write_data_strb_fifo_sync.sv | 69 ++++++
 rtl/axis_write_data_strb.sv | 138 +++++++++++++
 tb/tb_axis_write_data_strb.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_write_data_strb_pkg.sv
// Shared definitions for the AXI write-data engine and its write-address sibling:
// default widths, FSM encoding, beat-count and burst-split helpers.
package axis_write_data_strb_pkg;

  localparam int DEF_BUF_AWIDTH     = 4;
  localparam int DEF_CONFIG_DWIDTH  = 32;
  localparam int DEF_AXI_LEN_WIDTH  = 4;
  localparam int DEF_AXI_DATA_WIDTH = 64;
  localparam int DEF_DATA_WIDTH     = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Ceil(words / 2^shift). The 64-bit sum leaves headroom above any config width.
  function automatic logic [63:0] beats_from_words(input logic [63:0] words, input int shift);
    logic [63:0] ratio_m1;
    ratio_m1 = (64'd1 << shift) - 64'd1;
    return (words + ratio_m1) >> shift;
  endfunction

  function automatic int strb_width(input int axi_data_width);
    return axi_data_width / 8;
  endfunction

  // beat_num is 1-based from the start of the transfer.
  function automatic logic is_burst_end(input logic [63:0] beat_num, input int len_width,
                                        input logic final_beat);
    logic [63:0] mask;
    mask = (64'd1 << len_width) - 64'd1;
    return final_beat || ((beat_num & mask) == 64'd0);
  endfunction

endpackage

// File: rtl/axis_write_data_strb_if.sv
// Config, stream and AXI write-data signals of the engine; master is the engine side.
interface axis_write_data_strb_if #(
  parameter int CONFIG_DWIDTH  = axis_write_data_strb_pkg::DEF_CONFIG_DWIDTH,
  parameter int AXI_DATA_WIDTH = axis_write_data_strb_pkg::DEF_AXI_DATA_WIDTH,
  parameter int DATA_WIDTH     = axis_write_data_strb_pkg::DEF_DATA_WIDTH
);
  logic                        done;
  logic [CONFIG_DWIDTH-1:0]    cfg_length;
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic                        axi_wlast;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wvalid;
  logic                        axi_wready;
  logic [DATA_WIDTH-1:0]       data;
  logic                        valid;
  logic                        ready;

  modport master (
    output done, cfg_ready, axi_wlast, axi_wdata, axi_wstrb, axi_wvalid, ready,
    input  cfg_length, cfg_valid, axi_wready, data, valid
  );

  modport slave (
    input  done, cfg_ready, axi_wlast, axi_wdata, axi_wstrb, axi_wvalid, ready,
    output cfg_length, cfg_valid, axi_wready, data, valid
  );
endinterface

// File: rtl/axis_write_data_strb_fifo_sync.sv
// Synchronous FIFO, depth 2^ADDR_W, with the head entry and empty/full flags held in
// registers. A push into a full FIFO is accepted when a pop happens in the same cycle.
module axis_write_data_strb_fifo_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              do_push, do_pop;

  assign do_pop  = rd_en_i & ~empty_q;
  assign do_push = wr_en_i & (~full_q | do_pop);

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    // The head register follows the next entry, or the incoming one when it becomes the head.
    if (do_pop)                  rd_data_d = (count_q == CNT_ONE) ? wr_data_i : mem_q[rd_ptr_q + 1'b1];
    else if (do_push && empty_q) rd_data_d = wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CNT_FULL);
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: storage is not reset; pointers and flags alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_write_data_strb.sv
// AXI write-data engine: packs DATA_WIDTH words into AXI beats with byte strobes,
// marks burst ends with wlast, buffers beats and pulses done at transfer end.
module axis_write_data_strb
  import axis_write_data_strb_pkg::*;
#(
  parameter int BUF_AWIDTH     = DEF_BUF_AWIDTH,
  parameter int CONFIG_DWIDTH  = DEF_CONFIG_DWIDTH,
  parameter int AXI_LEN_WIDTH  = DEF_AXI_LEN_WIDTH,
  parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int WIDTH_RATIO    = AXI_DATA_WIDTH / DATA_WIDTH,
  parameter int CONVERT_SHIFT  = $clog2(WIDTH_RATIO)
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_write_data_strb_if.master bus
);
  localparam int STRB_WIDTH = strb_width(AXI_DATA_WIDTH);
  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int ENTRY_W    = AXI_DATA_WIDTH + STRB_WIDTH + 1;
  localparam int LANE_W     = (CONVERT_SHIFT > 0) ? CONVERT_SHIFT : 1;
  localparam logic [CONFIG_DWIDTH-1:0] ONE = CONFIG_DWIDTH'(1);

  state_e                    state_q, state_d;
  logic [CONFIG_DWIDTH-1:0]  words_left_q, words_left_d;
  logic [CONFIG_DWIDTH-1:0]  beats_left_q, beats_left_d;
  logic [CONFIG_DWIDTH-1:0]  beat_num_q, beat_num_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [AXI_DATA_WIDTH-1:0] pack_data_q, pack_data_d, merged_data;
  logic [STRB_WIDTH-1:0]     pack_strb_q, pack_strb_d, merged_strb;

  logic               cfg_ready, cfg_fire, word_fire, pop, push, last_word;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign cfg_ready = (state_q == S_IDLE) & ~rst;
  assign cfg_fire  = bus.cfg_valid & cfg_ready;
  assign pop       = ~fifo_empty & bus.axi_wready;
  // Any accepted word may complete a beat, so the buffer must have room (or be popping).
  assign bus.ready = (state_q == S_ACTIVE) & (words_left_q != '0) & (~fifo_full | pop);
  assign word_fire = bus.valid & bus.ready;
  assign last_word = (words_left_q == ONE);

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    beats_left_d = beats_left_q;
    beat_num_d   = beat_num_q;
    lane_d       = lane_q;
    pack_data_d  = pack_data_q;
    pack_strb_d  = pack_strb_q;
    push         = 1'b0;
    wr_entry     = '0;

    merged_data = pack_data_q;
    merged_strb = pack_strb_q;
    merged_data[lane_q*DATA_WIDTH +: DATA_WIDTH] = bus.data;
    merged_strb[lane_q*WORD_BYTES +: WORD_BYTES] = '1;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_fire) begin
          words_left_d = bus.cfg_length;
          beats_left_d = CONFIG_DWIDTH'(beats_from_words(64'(bus.cfg_length), CONVERT_SHIFT));
          beat_num_d   = '0;
          lane_d       = '0;
          pack_data_d  = '0;
          pack_strb_d  = '0;
          state_d      = (bus.cfg_length == '0) ? S_DONE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (word_fire) begin
          words_left_d = words_left_q - ONE;
          if (last_word || lane_q == LANE_W'(WIDTH_RATIO - 1)) begin
            push        = 1'b1;
            wr_entry    = {is_burst_end(64'(beat_num_q) + 64'd1, AXI_LEN_WIDTH, last_word),
                           merged_strb, merged_data};
            beat_num_d  = beat_num_q + ONE;
            lane_d      = '0;
            pack_data_d = '0;
            pack_strb_d = '0;
          end else begin
            lane_d      = lane_q + 1'b1;
            pack_data_d = merged_data;
            pack_strb_d = merged_strb;
          end
        end
        if (pop) begin
          beats_left_d = beats_left_q - ONE;
          if (beats_left_q == ONE) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      words_left_q <= '0;
      beats_left_q <= '0;
      beat_num_q   <= '0;
      lane_q       <= '0;
      pack_data_q  <= '0;
      pack_strb_q  <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      beats_left_q <= beats_left_d;
      beat_num_q   <= beat_num_d;
      lane_q       <= lane_d;
      pack_data_q  <= pack_data_d;
      pack_strb_q  <= pack_strb_d;
    end
  end

  axis_write_data_strb_fifo_sync #(
    .DATA_W (ENTRY_W),
    .ADDR_W (BUF_AWIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .full_o    (fifo_full),
    .rd_en_i   (bus.axi_wready),
    .rd_data_o (rd_entry),
    .empty_o   (fifo_empty)
  );

  assign bus.cfg_ready  = cfg_ready;
  assign bus.done       = (state_q == S_DONE);
  assign bus.axi_wvalid = ~fifo_empty;
  assign {bus.axi_wlast, bus.axi_wstrb, bus.axi_wdata} = rd_entry;

endmodule

// File: tb/tb_axis_write_data_strb.sv
// Directed bench for axis_write_data_strb: packing, strobes, burst wlast, backpressure,
// zero length and mid-transfer reset, with hand-computed expected beats.
module tb_axis_write_data_strb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   hs_cyc, done_cyc, done_cnt, wvalid_cnt, stall_err, gap_cnt, words_sent;
  bit   gap_watch, drv_busy, prev_stall;
  logic [72:0] prev_payload;

  logic [63:0] q_data [$];
  logic [7:0]  q_strb [$];
  logic        q_last [$];

  axis_write_data_strb_if bus ();

  axis_write_data_strb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observe at the falling edge; a beat seen valid&ready here handshakes at the next rise.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.axi_wvalid) wvalid_cnt++;
    if (prev_stall && !rst &&
        (!bus.axi_wvalid || {bus.axi_wlast, bus.axi_wstrb, bus.axi_wdata} != prev_payload))
      stall_err++;
    prev_stall   = bus.axi_wvalid & ~bus.axi_wready;
    prev_payload = {bus.axi_wlast, bus.axi_wstrb, bus.axi_wdata};
    if (bus.axi_wvalid && bus.axi_wready) begin
      q_data.push_back(bus.axi_wdata);
      q_strb.push_back(bus.axi_wstrb);
      q_last.push_back(bus.axi_wlast);
    end
    if (gap_watch && bus.valid && !bus.ready) gap_cnt++;
  end

  function automatic logic [72:0] exp_entry(input int i, input int len, input int first);
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
    int          nb;
    d  = '0;
    s  = '0;
    nb = (len + 1) / 2;
    for (int k = 0; k < 2; k++) begin
      if (2 * i + k < len) begin
        d[k*32 +: 32] = 32'(first + 2 * i + k);
        s[k*4 +: 4]   = 4'hF;
      end
    end
    l = ((i + 1) % 16 == 0) || (i == nb - 1);
    return {l, s, d};
  endfunction

  task automatic clear_beats();
    q_data.delete();
    q_strb.delete();
    q_last.delete();
  endtask

  task automatic start_cfg(input int len);
    bit hs;
    hs = 1'b0;
    @(posedge clk); #1;
    bus.cfg_length = 32'(len);
    bus.cfg_valid  = 1'b1;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = bus.cfg_ready;
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
    hs_cyc = cyc;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL cfg_handshake: cfg_ready=0 required 1 within 200 cycles");
    end
  endtask

  task automatic send_words(input int n, input int first);
    bit fire;
    drv_busy   = 1'b1;
    words_sent = 0;
    bus.data   = 32'(first);
    bus.valid  = (n > 0);
    for (int t = 0; t < 4000 && words_sent < n && !rst; t++) begin
      @(negedge clk);
      fire = bus.valid && bus.ready;
      @(posedge clk); #1;
      if (fire) begin
        words_sent++;
        bus.data = 32'(first + words_sent);
        if (words_sent == n) bus.valid = 1'b0;
      end
    end
    bus.valid = 1'b0;
    if (words_sent < n && !rst) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: sent=%0d required=%0d", words_sent, n);
    end
    drv_busy = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (done_cnt != base) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cfg_ready, bus.ready, bus.axi_wvalid, bus.axi_wlast, bus.done, bus.axi_wdata, bus.axi_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wvalid=%b cfg_ready=%b ready=%b wdata=%h required all 0",
               bus.axi_wvalid, bus.cfg_ready, bus.ready, bus.axi_wdata);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_ready: got %b required 1", bus.cfg_ready);
    end
  endtask

  task automatic test_basic();
    logic [63:0] exp_d [4] = '{64'h0000000200000001, 64'h0000000400000003,
                               64'h0000000600000005, 64'h0000000800000007};
    int  d0;
    bit  seen;
    bus.axi_wready = 1'b1;
    clear_beats();
    d0 = done_cnt;
    start_cfg(8);
    fork
      send_words(8, 1);
      wait_done(d0, seen);
    join
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_done: done not seen required 1 pulse"); end
    checks++;
    if (q_data.size() != 4) begin errors++; $display("FAIL basic_count: got %0d beats required 4", q_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %h required %h", i, q_data[i], exp_d[i]);
      end
    end
    checks++;
    if ({q_strb[0], q_strb[1], q_strb[2], q_strb[3]} !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL basic_strb: got %h %h %h %h required ff each", q_strb[0], q_strb[1], q_strb[2], q_strb[3]);
    end
    checks++;
    if ({q_last[3], q_last[2], q_last[1], q_last[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_wlast: got %b required 1000", {q_last[3], q_last[2], q_last[1], q_last[0]});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_once: pulses=%0d cfg_ready=%b required 1 and 1", done_cnt - d0, bus.cfg_ready);
    end
  endtask

  task automatic test_partial();
    int d0;
    bit seen;
    clear_beats();
    d0 = done_cnt;
    start_cfg(5);
    fork
      send_words(5, 1);
      wait_done(d0, seen);
    join
    checks++;
    if (!seen || q_data.size() != 3) begin
      errors++;
      $display("FAIL partial_count: done=%b beats=%0d required 1 and 3", seen, q_data.size());
    end
    checks++;
    if (q_data[0] !== 64'h0000000200000001 || q_strb[0] !== 8'hFF) begin
      errors++;
      $display("FAIL partial_beat1: got %h/%h required 0000000200000001/ff", q_data[0], q_strb[0]);
    end
    checks++;
    if ({q_last[2], q_strb[2], q_data[2]} !== {1'b1, 8'h0F, 64'h0000000000000005}) begin
      errors++;
      $display("FAIL partial_last_beat: got last=%b strb=%h data=%h required 1/0f/0000000000000005",
               q_last[2], q_strb[2], q_data[2]);
    end
    checks++;
    if ({q_last[2], q_last[1], q_last[0]} !== 3'b100) begin
      errors++;
      $display("FAIL partial_wlast: got %b required 100", {q_last[2], q_last[1], q_last[0]});
    end
  endtask

  task automatic test_long();
    int d0;
    bit seen;
    clear_beats();
    d0 = done_cnt;
    start_cfg(70);
    gap_cnt   = 0;
    gap_watch = 1'b1;
    fork
      send_words(70, 100);
      wait_done(d0, seen);
    join
    gap_watch = 1'b0;
    checks++;
    if (!seen || q_data.size() != 35) begin
      errors++;
      $display("FAIL long_count: done=%b beats=%0d required 1 and 35", seen, q_data.size());
    end
    for (int i = 0; i < 35; i++) begin
      checks++;
      if ({q_last[i], q_strb[i], q_data[i]} !== exp_entry(i, 70, 100)) begin
        errors++;
        $display("FAIL long_beat[%0d]: got %h required %h", i, {q_last[i], q_strb[i], q_data[i]}, exp_entry(i, 70, 100));
      end
    end
    checks++;
    if (gap_cnt != 0) begin errors++; $display("FAIL long_gaps: got %0d stalled cycles required 0", gap_cnt); end
  endtask

  task automatic test_backpressure();
    int d0;
    bit seen;
    clear_beats();
    bus.axi_wready = 1'b0;
    stall_err = 0;
    d0 = done_cnt;
    start_cfg(40);
    fork
      send_words(40, 1);
    join_none
    repeat (60) @(negedge clk);
    checks++;
    if (words_sent != 32 || bus.ready !== 1'b0 || q_data.size() != 0) begin
      errors++;
      $display("FAIL bp_fill: words=%0d ready=%b beats=%0d required 32/0/0", words_sent, bus.ready, q_data.size());
    end
    for (int t = 0; t < 400 && done_cnt == d0; t++) begin
      @(posedge clk); #1 bus.axi_wready = ~bus.axi_wready;
    end
    bus.axi_wready = 1'b1;
    seen = (done_cnt != d0);
    for (int t = 0; t < 100 && drv_busy; t++) @(negedge clk);
    checks++;
    if (!seen || q_data.size() != 20) begin
      errors++;
      $display("FAIL bp_count: done=%b beats=%0d required 1 and 20", seen, q_data.size());
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({q_last[i], q_strb[i], q_data[i]} !== exp_entry(i, 40, 1)) begin
        errors++;
        $display("FAIL bp_beat[%0d]: got %h required %h", i, {q_last[i], q_strb[i], q_data[i]}, exp_entry(i, 40, 1));
      end
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_err); end
  endtask

  task automatic test_zero();
    int d0;
    bit seen;
    bus.axi_wready = 1'b1;
    wvalid_cnt = 0;
    d0 = done_cnt;
    start_cfg(0);
    wait_done(d0, seen);
    checks++;
    if (!seen || done_cyc - hs_cyc > 1) begin
      errors++;
      $display("FAIL zero_done: seen=%b delay=%0d required 1 and <=1", seen, done_cyc - hs_cyc);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || wvalid_cnt != 0) begin
      errors++;
      $display("FAIL zero_quiet: pulses=%0d wvalid_cycles=%0d required 1 and 0", done_cnt - d0, wvalid_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit seen;
    bus.axi_wready = 1'b1;
    clear_beats();
    start_cfg(8);
    fork
      send_words(8, 1);
    join_none
    for (int t = 0; t < 200 && q_data.size() < 2; t++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cfg_ready, bus.ready, bus.axi_wvalid, bus.axi_wlast, bus.done, bus.axi_wdata, bus.axi_wstrb} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: wvalid=%b wdata=%h ready=%b required all 0",
               bus.axi_wvalid, bus.axi_wdata, bus.ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 50 && drv_busy; t++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL midreset_cfg_ready: got %b required 1", bus.cfg_ready); end
    clear_beats();
    repeat (3) @(negedge clk);
    checks++;
    if (q_data.size() != 0 || bus.axi_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_beats: beats=%0d wvalid=%b required 0 and 0", q_data.size(), bus.axi_wvalid);
    end
    d0 = done_cnt;
    start_cfg(2);
    fork
      send_words(2, 1);
      wait_done(d0, seen);
    join
    checks++;
    if (!seen || q_data.size() != 1 || {q_last[0], q_strb[0], q_data[0]} !== {1'b1, 8'hFF, 64'h0000000200000001}) begin
      errors++;
      $display("FAIL midreset_new_xfer: done=%b beats=%0d beat=%h required 1/1/1ff0000000200000001",
               seen, q_data.size(), {q_last[0], q_strb[0], q_data[0]});
    end
  endtask

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_length = '0;
    bus.valid      = 1'b0;
    bus.data       = '0;
    bus.axi_wready = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_long();
    test_backpressure();
    test_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
